// File: rtl/prog_mem.sv
// Writable program memory with a registered fetch port, a byte-wide loader
// and a post-reset sweep that fills every word with FILL_WORD.
module prog_mem #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned DATA_W = 16,
   parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(16'b00110100_00000000)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid,
   output logic              cpu_hold,
   input  logic              ld_start,
   input  logic [ADDR_W-1:0] ld_base,
   input  logic [7:0]        ld_byte,
   input  logic              ld_byte_valid,
   output logic              ld_ready,
   input  logic              ld_end,
   output logic              ld_err
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned AW1   = ADDR_W + 1;

   typedef enum logic [1:0] {S_CLEAR, S_RUN, S_LOAD} state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   ptr, ptr_d;
   logic [AW1-1:0]      wptr, wptr_d;
   logic [BI_W-1:0]     byte_idx, byte_idx_d;
   logic [DATA_W-1:0]   asm_word, asm_word_d;
   logic                ovf, ovf_d;
   logic [DATA_W-1:0]   fetch_data_d;
   logic                fetch_valid_d, cpu_hold_d, ld_ready_d, ld_err_d;
   logic                we;
   logic [ADDR_W-1:0]   waddr;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W-1:0]   word_c;

   logic [DATA_W-1:0]   mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_CLEAR;
         ptr         <= '0;
         wptr        <= '0;
         byte_idx    <= '0;
         asm_word    <= '0;
         ovf         <= 1'b0;
         fetch_data  <= FILL_WORD;
         fetch_valid <= 1'b0;
         cpu_hold    <= 1'b1;
         ld_ready    <= 1'b0;
         ld_err      <= 1'b0;
      end else begin
         state       <= state_d;
         ptr         <= ptr_d;
         wptr        <= wptr_d;
         byte_idx    <= byte_idx_d;
         asm_word    <= asm_word_d;
         ovf         <= ovf_d;
         fetch_data  <= fetch_data_d;
         fetch_valid <= fetch_valid_d;
         cpu_hold    <= cpu_hold_d;
         ld_ready    <= ld_ready_d;
         ld_err      <= ld_err_d;
      end
   end

   // Storage has no reset; the CLEAR sweep defines its contents.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign word_c = (asm_word << 8) | DATA_W'(ld_byte);

   always_comb begin
      state_d       = state;
      ptr_d         = ptr;
      wptr_d        = wptr;
      byte_idx_d    = byte_idx;
      asm_word_d    = asm_word;
      ovf_d         = ovf;
      fetch_data_d  = fetch_data;
      fetch_valid_d = 1'b0;
      ld_err_d      = ld_err;
      we            = 1'b0;
      waddr         = ptr;
      wdata         = FILL_WORD;

      unique case (state)
         S_CLEAR: begin
            we    = 1'b1;
            ptr_d = ptr + ADDR_W'(1);
            if (ptr == ADDR_W'(DEPTH - 1)) begin
               ptr_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (ld_start) begin
               state_d    = S_LOAD;
               wptr_d     = {1'b0, ld_base};
               byte_idx_d = '0;
               asm_word_d = '0;
               ovf_d      = 1'b0;
               ld_err_d   = 1'b0;
            end else if (fetch_req) begin
               fetch_valid_d = 1'b1;
               fetch_data_d  = ({1'b0, fetch_addr} < AW1'(DEPTH)) ? mem[fetch_addr] : FILL_WORD;
            end
         end
         S_LOAD: begin
            // After an overflow every byte is dropped until the end pulse.
            if (ld_byte_valid && !ovf) begin
               asm_word_d = word_c;
               if (byte_idx == BI_W'(BYTES - 1)) begin
                  byte_idx_d = '0;
                  if (wptr < AW1'(DEPTH)) begin
                     we     = 1'b1;
                     waddr  = wptr[ADDR_W-1:0];
                     wdata  = word_c;
                     wptr_d = wptr + AW1'(1);
                  end else begin
                     ovf_d    = 1'b1;
                     ld_err_d = 1'b1;
                  end
               end else begin
                  byte_idx_d = byte_idx + BI_W'(1);
               end
            end
            if (ld_end) begin
               state_d = S_RUN;
               if (byte_idx_d != '0) ld_err_d = 1'b1;
               byte_idx_d = '0;
            end
         end
         default: state_d = S_CLEAR;
      endcase

      cpu_hold_d = (state_d != S_RUN);
      ld_ready_d = (state_d == S_LOAD);
   end

endmodule
